fc_rx_deframer: RTL and testbench
=================================

FC_RX_DEFRAMER -- requirements
Module: fc_rx_deframer

Interface
REQ-001 SHALL have parameter MAX_FRAME_WORDS, default 537, the maximum words per frame including SOF and EOF.
REQ-002 SHALL have parameter MIN_FRAME_WORDS, default 9, the minimum words per frame including SOF and EOF.
REQ-003 SHALL have parameter CNT_WIDTH, default 32, the statistics counter width (1..32).
REQ-004 SHALL have derived localparam LEN_WIDTH = $clog2(MAX_FRAME_WORDS+1).
REQ-005 clk  in  1  sole clock; all logic on its rising edge.
REQ-006 reset_n  in  1  synchronous, active-low reset.
REQ-007 avrx_data  in  36  [35:32] datak per byte, [31:0] data, byte 3 first on the wire.
REQ-008 avrx_valid  in  1  word valid (decoder locked).
REQ-009 userrx_data  out  32  frame word.
REQ-010 userrx_valid / userrx_startofpacket / userrx_endofpacket  out  1 each  Avalon-ST, no backpressure.
REQ-011 userrx_error  out  1  qualifies the eop beat; the frame is bad.
REQ-012 userrx_length  out  LEN_WIDTH  frame word count, valid on the eop beat, 0 otherwise.
REQ-013 mm_address  in  3; mm_read  in  1; mm_readdata  out  32  statistics registers.

Function
REQ-014 SOF word SHALL be: datak==4'b1000, data[31:16]==16'hBCB5, data[15:8]==data[7:0], and the low byte is one of 56,36,55,35,58.
REQ-015 EOF word SHALL be: datak==4'b1000, data[31:24]==8'hBC, data[15:8]==data[7:0], and either (byte2 in {95,B5} and low byte in {75,D5,F5}) or (byte2 in {8A,AA} and low byte D5).
REQ-016 EOFa SHALL be low byte F5 with byte2 95/B5; EOFni SHALL be byte2 8A/AA.
REQ-017 SHALL use a data word (datak==0), SOF, EOF and other-K (any other datak!=0) as the word classes.
REQ-018 SHALL have states IDLE, FRAME and DISCARD; len SHALL be the count of words emitted in the current frame.
REQ-019 All outputs SHALL be registered; an input at edge N appears on userrx_* at edge N+1.
REQ-020 IDLE: SOF -> emit with sop=1, len=1, go FRAME; data/EOF -> drop, stray++; other-K -> drop silently.
REQ-021 FRAME, data with len<MAX -> emit, len++.
REQ-022 FRAME, EOF with len<MAX -> emit with eop=1, userrx_length=len+1, go IDLE.
REQ-023 On a FRAME EOF, error=1 if len+1<MIN_FRAME_WORDS, or the EOF is EOFa or EOFni; error=1 SHALL increment frames_err, else frames_ok.
REQ-024 FRAME, data/EOF with len==MAX -> emit synthetic terminator, frames_err++, go DISCARD (EOF-case: go IDLE).
REQ-025 FRAME, SOF or other-K -> emit synthetic terminator, frames_err++, go DISCARD; the new SOF is dropped.
REQ-026 Synthetic terminator SHALL be valid=1, sop=0, eop=1, error=1, data=32'h0, userrx_length=len.
REQ-027 DISCARD: EOF -> drop, go IDLE; SOF -> handle as IDLE SOF; all else dropped.
REQ-028 avrx_valid=0 SHALL suppress classification; FRAME with avrx_valid=0 -> terminator next cycle, frames_err++, go IDLE.
REQ-029 avrx_valid=0 in DISCARD SHALL go IDLE.
REQ-030 Non-emitting cycles SHALL drive userrx_valid=0 and sop=eop=error=0.
REQ-031 Counters SHALL saturate at 2^CNT_WIDTH-1.
REQ-032 A frame of exactly MAX words (EOF at len==MAX-1) SHALL be legal.
REQ-033 mm_readdata SHALL update one cycle after mm_read=1 and hold otherwise.
REQ-034 Register map (counters zero-extended): 0 frames_ok, 1 frames_err, 2 stray, 3 {28'h0, 2'b0, state[1:0]} with IDLE=0, FRAME=1, DISCARD=2, 4 MAX_FRAME_WORDS, 5 MIN_FRAME_WORDS, 6-7 32'hFFFFFFFF.

Reset
REQ-035 reset_n=0 at an edge SHALL force state IDLE, len 0, all counters 0, and all userrx_* outputs and mm_readdata 0.
REQ-036 Reset mid-frame SHALL emit no terminator and count no error.
REQ-037 The first SOF after reset_n returns high SHALL start a frame normally.

Verification
REQ-038 SOF BCB55656, 7 data words, EOF BC957575 -> 9 beats, sop on beat 1, eop on beat 9, error=0, length=9, reg0=1.
REQ-039 SOF, 3 data words, EOF -> eop with error=1, length=5, reg1=1.
REQ-040 MAX_FRAME_WORDS=16: SOF and 20 data words -> 16 beats, then terminator (data 0, error=1, length=16); no output until the next SOF.
REQ-041 Mid-frame SOF -> terminator that cycle, the new frame is dropped through its EOF, reg1 increments.
REQ-042 Stray: 3 data words then EOF while IDLE -> no output, reg2=4.
REQ-043 avrx_valid low for 1 cycle at word 5 -> terminator with length=4, state IDLE; later words are dropped as stray.

Source files
------------

// File: rtl/fc_rx_deframer.sv
// fc_rx_deframer: Fibre Channel receive deframer with Avalon-ST output and saturating statistics registers
module fc_rx_deframer #(
    parameter int MAX_FRAME_WORDS = 537,
    parameter int MIN_FRAME_WORDS = 9,
    parameter int CNT_WIDTH = 32,
    localparam int LEN_WIDTH = $clog2(MAX_FRAME_WORDS + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [35:0]          avrx_data,
    input  logic                 avrx_valid,
    output logic [31:0]          userrx_data,
    output logic                 userrx_valid,
    output logic                 userrx_startofpacket,
    output logic                 userrx_endofpacket,
    output logic                 userrx_error,
    output logic [LEN_WIDTH-1:0] userrx_length,
    input  logic [2:0]           mm_address,
    input  logic                 mm_read,
    output logic [31:0]          mm_readdata
);
    typedef enum logic [1:0] {IDLE = 2'd0, FRAME = 2'd1, DISCARD = 2'd2} state_t;
    state_t state, state_nx;
    logic [LEN_WIDTH-1:0] len, len_nx, len_inc, lout;
    logic [CNT_WIDTH-1:0] frames_ok, frames_err, stray;
    logic inc_ok, inc_err, inc_stray, emit, sop, eop, err;
    logic [31:0] dout, rd_mux;
    logic [3:0] k;
    logic [7:0] b3, b2, b1, b0;
    logic is_data, is_sof, is_eof, eof_bad, at_max, short_frame;
    assign k = avrx_data[35:32];
    assign {b3, b2, b1, b0} = avrx_data[31:0];
    assign is_data = k == 4'h0;
    assign is_sof = k == 4'b1000 && b3 == 8'hBC && b2 == 8'hB5 && b1 == b0 &&
                    (b0 == 8'h56 || b0 == 8'h36 || b0 == 8'h55 || b0 == 8'h35 || b0 == 8'h58);
    assign is_eof = k == 4'b1000 && b3 == 8'hBC && b1 == b0 &&
                    (((b2 == 8'h95 || b2 == 8'hB5) && (b0 == 8'h75 || b0 == 8'hD5 || b0 == 8'hF5)) ||
                     ((b2 == 8'h8A || b2 == 8'hAA) && b0 == 8'hD5));
    assign eof_bad = b0 == 8'hF5 || b2 == 8'h8A || b2 == 8'hAA;
    assign len_inc = len + LEN_WIDTH'(1);
    assign at_max = len == LEN_WIDTH'(MAX_FRAME_WORDS);
    assign short_frame = 32'(len_inc) < 32'(MIN_FRAME_WORDS);
    always_comb begin
        state_nx = state;
        len_nx = len;
        emit = 1'b0;
        sop = 1'b0;
        eop = 1'b0;
        err = 1'b0;
        dout = avrx_data[31:0];
        lout = '0;
        inc_ok = 1'b0;
        inc_err = 1'b0;
        inc_stray = 1'b0;
        case (state)
            FRAME: begin
                if (!avrx_valid || !(is_data || is_eof) || at_max) begin
                    emit = 1'b1;
                    eop = 1'b1;
                    err = 1'b1;
                    dout = '0;
                    lout = len;
                    inc_err = 1'b1;
                    len_nx = '0;
                    state_nx = (!avrx_valid || is_eof) ? IDLE : DISCARD;
                end else if (is_eof) begin
                    emit = 1'b1;
                    eop = 1'b1;
                    err = short_frame || eof_bad;
                    lout = len_inc;
                    inc_ok = !err;
                    inc_err = err;
                    len_nx = '0;
                    state_nx = IDLE;
                end else begin
                    emit = 1'b1;
                    len_nx = len_inc;
                end
            end
            default: begin
                if (!avrx_valid) begin
                    state_nx = IDLE;
                end else if (is_sof) begin
                    emit = 1'b1;
                    sop = 1'b1;
                    len_nx = LEN_WIDTH'(1);
                    state_nx = FRAME;
                end else if (state == IDLE) begin
                    inc_stray = is_data || is_eof;
                end else if (is_eof) begin
                    state_nx = IDLE;
                end
            end
        endcase
    end
    always_comb
        rd_mux = mm_address == 3'd0 ? 32'(frames_ok) :
                 mm_address == 3'd1 ? 32'(frames_err) :
                 mm_address == 3'd2 ? 32'(stray) :
                 mm_address == 3'd3 ? {30'h0, state} :
                 mm_address == 3'd4 ? 32'(MAX_FRAME_WORDS) :
                 mm_address == 3'd5 ? 32'(MIN_FRAME_WORDS) : 32'hFFFF_FFFF;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            len <= '0;
            frames_ok <= '0;
            frames_err <= '0;
            stray <= '0;
            userrx_data <= '0;
            userrx_valid <= 1'b0;
            userrx_startofpacket <= 1'b0;
            userrx_endofpacket <= 1'b0;
            userrx_error <= 1'b0;
            userrx_length <= '0;
            mm_readdata <= '0;
        end else begin
            state <= state_nx;
            len <= len_nx;
            if (inc_ok && frames_ok != '1) frames_ok <= frames_ok + CNT_WIDTH'(1);
            if (inc_err && frames_err != '1) frames_err <= frames_err + CNT_WIDTH'(1);
            if (inc_stray && stray != '1) stray <= stray + CNT_WIDTH'(1);
            userrx_data <= dout;
            userrx_valid <= emit;
            userrx_startofpacket <= sop;
            userrx_endofpacket <= eop;
            userrx_error <= err;
            userrx_length <= lout;
            if (mm_read) mm_readdata <= rd_mux;
        end
    end
endmodule

// File: tb/tb_fc_rx_deframer.sv
// tb_fc_rx_deframer: episode-level randomized bench for fc_rx_deframer with an expected-beat queue
module tb_fc_rx_deframer;
    localparam int MAXW = 16, MINW = 9, CW = 5, SAT = 31, LW = $clog2(MAXW + 1);
    logic clk = 1'b0, reset_n = 1'b0, avrx_valid = 1'b0, mm_read = 1'b0;
    logic [35:0] avrx_data = '0;
    logic [2:0] mm_address = '0;
    logic [31:0] userrx_data, mm_readdata;
    logic userrx_valid, userrx_startofpacket, userrx_endofpacket, userrx_error;
    logic [LW-1:0] userrx_length;
    int n_chk = 0, n_fail = 0, m_ok = 0, m_err = 0, m_stray = 0;
    logic [39:0] expq[$];
    logic [31:0] sof_tab[5] = '{32'hBCB55656, 32'hBCB53636, 32'hBCB55555, 32'hBCB53535, 32'hBCB55858};
    logic [31:0] eof_tab[8] = '{32'hBC957575, 32'hBCB5D5D5, 32'hBC95D5D5, 32'hBCB57575,
                                32'hBC95F5F5, 32'hBCB5F5F5, 32'hBC8AD5D5, 32'hBCAAD5D5};
    bit eof_abn[8] = '{0, 0, 0, 0, 1, 1, 1, 1};

    fc_rx_deframer #(.MAX_FRAME_WORDS(MAXW), .MIN_FRAME_WORDS(MINW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n), .avrx_data(avrx_data), .avrx_valid(avrx_valid),
        .userrx_data(userrx_data), .userrx_valid(userrx_valid),
        .userrx_startofpacket(userrx_startofpacket), .userrx_endofpacket(userrx_endofpacket),
        .userrx_error(userrx_error), .userrx_length(userrx_length),
        .mm_address(mm_address), .mm_read(mm_read), .mm_readdata(mm_readdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [39:0] bt(input logic [31:0] d, input logic s, input logic e, input logic r, input int l);
        return {d, s, e, r, 5'(l)};
    endfunction

    function automatic int inc(input int c);
        return c < SAT ? c + 1 : c;
    endfunction

    always @(negedge clk) begin
        if (userrx_valid)
            chk("beat", {userrx_data, userrx_startofpacket, userrx_endofpacket, userrx_error, userrx_length},
                expq.size() != 0 ? expq.pop_front() : '1);
        else
            chk("idle", {userrx_startofpacket, userrx_endofpacket, userrx_error, userrx_length}, 0);
    end

    task automatic put(input logic v, input logic [3:0] k, input logic [31:0] d);
        avrx_valid = v;
        avrx_data = {k, d};
        @(posedge clk);
        #1;
    endtask

    task automatic otherk();
        put(1'b1, 4'($urandom_range(1, 7)), $urandom);
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
        mm_address = a;
        mm_read = 1'b1;
        otherk();
        mm_read = 1'b0;
        chk(tag, mm_readdata, exp);
    endtask

    task automatic frame(input int n, input logic [31:0] sw, input int ei);
        logic [31:0] d[$];
        bit bad;
        for (int i = 0; i < n; i++) d.push_back($urandom);
        bad = n + 2 < MINW || eof_abn[ei];
        expq.push_back(bt(sw, 1, 0, 0, 0));
        foreach (d[i]) expq.push_back(bt(d[i], 0, 0, 0, 0));
        expq.push_back(bt(eof_tab[ei], 0, 1, bad, n + 2));
        if (bad) m_err = inc(m_err); else m_ok = inc(m_ok);
        put(1'b1, 4'b1000, sw);
        foreach (d[i]) put(1'b1, 4'h0, d[i]);
        put(1'b1, 4'b1000, eof_tab[ei]);
    endtask

    task automatic oversize(input int m, input bit with_eof);
        logic [31:0] d[$];
        logic [31:0] sw;
        sw = sof_tab[$urandom_range(0, 4)];
        for (int i = 0; i < m; i++) d.push_back($urandom);
        expq.push_back(bt(sw, 1, 0, 0, 0));
        for (int i = 0; i < MAXW - 1; i++) expq.push_back(bt(d[i], 0, 0, 0, 0));
        expq.push_back(bt(32'h0, 0, 1, 1, MAXW));
        m_err = inc(m_err);
        put(1'b1, 4'b1000, sw);
        foreach (d[i]) put(1'b1, 4'h0, d[i]);
        if (with_eof) put(1'b1, 4'b1000, eof_tab[$urandom_range(0, 7)]);
    endtask

    task automatic abort(input int j, input bit use_sof, input int k);
        logic [31:0] d[$];
        logic [31:0] sw;
        sw = sof_tab[$urandom_range(0, 4)];
        for (int i = 0; i < j; i++) d.push_back($urandom);
        expq.push_back(bt(sw, 1, 0, 0, 0));
        foreach (d[i]) expq.push_back(bt(d[i], 0, 0, 0, 0));
        expq.push_back(bt(32'h0, 0, 1, 1, j + 1));
        m_err = inc(m_err);
        put(1'b1, 4'b1000, sw);
        foreach (d[i]) put(1'b1, 4'h0, d[i]);
        if (use_sof) put(1'b1, 4'b1000, sof_tab[$urandom_range(0, 4)]); else otherk();
        for (int i = 0; i < k; i++) put(1'b1, 4'h0, $urandom);
        put(1'b1, 4'b1000, eof_tab[$urandom_range(0, 7)]);
    endtask

    task automatic vdrop(input int j);
        logic [31:0] d[$];
        logic [31:0] sw;
        sw = sof_tab[$urandom_range(0, 4)];
        for (int i = 0; i < j; i++) d.push_back($urandom);
        expq.push_back(bt(sw, 1, 0, 0, 0));
        foreach (d[i]) expq.push_back(bt(d[i], 0, 0, 0, 0));
        expq.push_back(bt(32'h0, 0, 1, 1, j + 1));
        m_err = inc(m_err);
        put(1'b1, 4'b1000, sw);
        foreach (d[i]) put(1'b1, 4'h0, d[i]);
        put(1'b0, 4'($urandom), $urandom);
    endtask

    task automatic stray(input int r);
        for (int i = 0; i < r; i++) begin
            if (i == r - 1) put(1'b1, 4'b1000, eof_tab[$urandom_range(0, 7)]);
            else put(1'b1, 4'h0, $urandom);
            m_stray = inc(m_stray);
            if ($urandom_range(0, 1) == 1) otherk();
        end
    endtask

    task automatic gap(input int g);
        for (int i = 0; i < g; i++)
            if ($urandom_range(0, 1) == 1) otherk(); else put(1'b0, 4'($urandom), $urandom);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        put(1'b1, 4'h0, $urandom);
        reset_n = 1'b1;
        m_ok = 0;
        m_err = 0;
        m_stray = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", {userrx_valid, userrx_startofpacket, userrx_endofpacket, userrx_error, userrx_data, userrx_length}, 0);
        chk("rst_mm", mm_readdata, 0);
        reset_n = 1'b1;
        frame(7, 32'hBCB55656, 0);
        rd(3'd0, 1, "ok_after_good");
        frame(3, sof_tab[1], 0);
        rd(3'd1, 1, "err_after_short");
        oversize(20, 0);
        rd(3'd3, 2, "state_discard");
        rd(3'd2, 0, "stray_in_discard");
        put(1'b0, 4'h0, 32'h0);
        rd(3'd3, 0, "state_idle");
        abort(3, 1, 4);
        rd(3'd1, m_err, "err_after_abort");
        stray(4);
        rd(3'd2, 4, "stray_four");
        vdrop(4);
        rd(3'd3, 0, "state_after_vdrop");
        stray(3);
        rd(3'd2, m_stray, "stray_after_vdrop");
        frame(MAXW - 2, sof_tab[2], 1);
        oversize(MAXW - 1, 1);
        rd(3'd0, m_ok, "ok_max_frame");
        rd(3'd1, m_err, "err_eof_at_max");
        frame(8, sof_tab[3], 4);
        frame(8, sof_tab[4], 6);
        rd(3'd1, m_err, "err_eofa_eofni");
        rd(3'd4, MAXW, "reg_max");
        rd(3'd5, MINW, "reg_min");
        rd(3'd6, 32'hFFFF_FFFF, "reg6");
        rd(3'd7, 32'hFFFF_FFFF, "reg7");
        mm_address = 3'd0;
        otherk();
        chk("mm_hold", mm_readdata, 32'hFFFF_FFFF);
        expq.push_back(bt(32'hBCB55656, 1, 0, 0, 0));
        expq.push_back(bt(32'h1234_5678, 0, 0, 0, 0));
        expq.push_back(bt(32'h9ABC_DEF0, 0, 0, 0, 0));
        put(1'b1, 4'b1000, 32'hBCB55656);
        put(1'b1, 4'h0, 32'h1234_5678);
        put(1'b1, 4'h0, 32'h9ABC_DEF0);
        do_reset();
        rd(3'd1, 0, "err_after_reset");
        rd(3'd0, 0, "ok_after_reset");
        rd(3'd3, 0, "state_after_reset");
        frame(9, sof_tab[0], 1);
        rd(3'd0, 1, "ok_first_after_reset");
        stray(40);
        rd(3'd2, SAT, "stray_saturated");
        do_reset();
        for (int e = 0; e < 300; e++) begin
            case ($urandom_range(0, 5))
                0, 1: frame($urandom_range(0, MAXW - 2), sof_tab[$urandom_range(0, 4)], $urandom_range(0, 7));
                2: oversize($urandom_range(MAXW - 1, MAXW + 2), 1);
                3: abort($urandom_range(0, 5), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
                4: vdrop($urandom_range(0, 12));
                default: stray($urandom_range(1, 3));
            endcase
            gap($urandom_range(0, 2));
            if (e % 10 == 9) begin
                rd(3'd0, m_ok, "rand_ok");
                rd(3'd1, m_err, "rand_err");
                rd(3'd2, m_stray, "rand_stray");
                rd(3'd3, 0, "rand_state");
            end
        end
        repeat (3) put(1'b0, 4'h0, 32'h0);
        chk("drain", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
